// File: rtl/vrf_pkg.sv
// Shared constants and helpers for the vector register file write path.
package vrf_pkg;

   localparam int ADDR_W = 4;
   localparam int WORD_W = 32;

   localparam logic [ADDR_W-1:0] VREG_ZERO = 4'd0;
   localparam logic [ADDR_W-1:0] VREG_BTN  = 4'd12;
   localparam logic [ADDR_W-1:0] VREG_Y    = 4'd13;
   localparam logic [ADDR_W-1:0] VREG_LANE = 4'd14;
   localparam logic [ADDR_W-1:0] VREG_TIME = 4'd15;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_LDU = 1'b1
   } src_e;

   function automatic logic is_writable(input logic [ADDR_W-1:0] addr);
      return !(addr == VREG_ZERO || addr == VREG_BTN || addr == VREG_Y ||
               addr == VREG_LANE || addr == VREG_TIME);
   endfunction

endpackage

// File: rtl/vrf_write_scheduler_rr_arb2.sv
// Two-way round-robin arbiter; req[0]/gnt[0] is the ALU, req[1]/gnt[1] the load unit.
module rr_arb2
   import vrf_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt
);

   src_e r_ptr;

   always_comb begin
      o_gnt = 2'b00;
      unique case (i_req)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         2'b11:   o_gnt = (r_ptr == SRC_ALU) ? 2'b01 : 2'b10;
         default: o_gnt = 2'b00;
      endcase
   end

   // Only contested cycles move the pointer.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_ptr <= SRC_ALU;
      end else if (&i_req) begin
         r_ptr <= (r_ptr == SRC_ALU) ? SRC_LDU : SRC_ALU;
      end
   end

endmodule

// File: rtl/vrf_write_scheduler.sv
// Shares the VRF write port between ALU and load writeback and
// tracks pending writes per register for decode hazard stalls.
module vrf_write_scheduler
   import vrf_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 4,
   parameter int REG_COUNT  = 16
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_alu_valid,
   input  logic [ADDR_W-1:0]           i_alu_addr,
   input  logic [DATA_WIDTH*LANES-1:0] i_alu_data,
   output logic                        o_alu_ready,
   input  logic                        i_ldu_valid,
   input  logic [ADDR_W-1:0]           i_ldu_addr,
   input  logic [DATA_WIDTH*LANES-1:0] i_ldu_data,
   output logic                        o_ldu_ready,
   input  logic                        i_rsv_valid,
   input  logic [ADDR_W-1:0]           i_rsv_addr,
   input  logic [ADDR_W-1:0]           i_chk_addr1,
   input  logic [ADDR_W-1:0]           i_chk_addr2,
   output logic                        o_stall,
   output logic [REG_COUNT-1:0]        o_busy,
   output logic                        o_we,
   output logic [ADDR_W-1:0]           o_w_addr,
   output logic [DATA_WIDTH*LANES-1:0] o_w_data,
   output logic                        o_drop
);

   localparam int DW = DATA_WIDTH * LANES;

   logic [1:0]           w_gnt;
   logic                 w_hs_alu;
   logic                 w_hs_ldu;
   logic                 w_hs;
   logic [ADDR_W-1:0]    w_sel_addr;
   logic [DW-1:0]        w_sel_data;
   logic                 w_sel_wr;
   logic [REG_COUNT-1:0] w_set;
   logic [REG_COUNT-1:0] w_clr;

   logic                 r_we;
   logic [ADDR_W-1:0]    r_waddr;
   logic [DW-1:0]        r_wdata;
   logic                 r_drop;
   logic [REG_COUNT-1:0] r_busy;

   rr_arb2 u_arb (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_req   ({i_ldu_valid, i_alu_valid}),
      .o_gnt   (w_gnt)
   );

   assign o_alu_ready = i_alu_valid & w_gnt[0] & i_rst_n;
   assign o_ldu_ready = i_ldu_valid & w_gnt[1] & i_rst_n;

   assign w_hs_alu   = o_alu_ready;
   assign w_hs_ldu   = o_ldu_ready;
   assign w_hs       = w_hs_alu | w_hs_ldu;
   assign w_sel_addr = w_hs_ldu ? i_ldu_addr : i_alu_addr;
   assign w_sel_data = w_hs_ldu ? i_ldu_data : i_alu_data;
   assign w_sel_wr   = is_writable(w_sel_addr);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_we    <= 1'b0;
         r_drop  <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else begin
         r_we   <= w_hs & w_sel_wr;
         r_drop <= w_hs & ~w_sel_wr;
         if (w_hs && w_sel_wr) begin
            r_waddr <= w_sel_addr;
            r_wdata <= w_sel_data;
         end
      end
   end

   assign o_stall = r_busy[i_chk_addr1] | r_busy[i_chk_addr2] |
                    (i_rsv_valid & r_busy[i_rsv_addr]);

   // A stalled reservation is re-presented by decode, so it is not recorded.
   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (i_rsv_valid && is_writable(i_rsv_addr) && !o_stall) begin
         w_set = REG_COUNT'(1) << i_rsv_addr;
      end
      if (r_we) begin
         w_clr = REG_COUNT'(1) << r_waddr;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_busy <= '0;
      end else begin
         r_busy <= (r_busy & ~w_clr) | w_set;
      end
   end

   assign o_busy   = r_busy;
   assign o_we     = r_we;
   assign o_w_addr = r_waddr;
   assign o_w_data = r_wdata;
   assign o_drop   = r_drop;

endmodule

// File: tb/tb_vrf_write_scheduler.sv
// Directed bench with a write-expectation queue drained by a monitor.
module tb_vrf_write_scheduler;

   typedef struct {
      logic        drop;
      logic [3:0]  addr;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_valid, ldu_valid, rsv_valid;
   logic [3:0]  alu_addr, ldu_addr, rsv_addr, chk1, chk2;
   logic [31:0] alu_data, ldu_data;
   logic        alu_ready, ldu_ready, stall, we, drop;
   logic [15:0] busy;
   logic [3:0]  w_addr;
   logic [31:0] w_data;

   int   tests = 0;
   int   fails = 0;
   exp_t q[$];
   exp_t m_e;

   always #5 clk = ~clk;

   vrf_write_scheduler dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_alu_valid (alu_valid),
      .i_alu_addr  (alu_addr),
      .i_alu_data  (alu_data),
      .o_alu_ready (alu_ready),
      .i_ldu_valid (ldu_valid),
      .i_ldu_addr  (ldu_addr),
      .i_ldu_data  (ldu_data),
      .o_ldu_ready (ldu_ready),
      .i_rsv_valid (rsv_valid),
      .i_rsv_addr  (rsv_addr),
      .i_chk_addr1 (chk1),
      .i_chk_addr2 (chk2),
      .o_stall     (stall),
      .o_busy      (busy),
      .o_we        (we),
      .o_w_addr    (w_addr),
      .o_w_data    (w_data),
      .o_drop      (drop)
   );

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic d, input logic [3:0] a,
                       input logic [31:0] v);
      exp_t e;
      e.drop = d;
      e.addr = a;
      e.data = v;
      q.push_back(e);
   endtask

   // Monitor: every registered write or drop must match the next expectation.
   always @(negedge clk) begin
      if (we === 1'b1 || drop === 1'b1) begin
         if (q.size() == 0) begin
            check("unexpected_write", {30'd0, we, drop}, 32'd0);
         end else begin
            m_e = q.pop_front();
            check("mon_we", {31'd0, we}, {31'd0, ~m_e.drop});
            check("mon_drop", {31'd0, drop}, {31'd0, m_e.drop});
            if (!m_e.drop) begin
               check("mon_addr", {28'd0, w_addr}, {28'd0, m_e.addr});
               check("mon_data", w_data, m_e.data);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 32'h0;
      ldu_valid = 1'b0; ldu_addr = 4'd0; ldu_data = 32'h0;
      rsv_valid = 1'b0; rsv_addr = 4'd0; chk1 = 4'd0; chk2 = 4'd0;
      cyc();
      cyc();
      check("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
      check("rst_we", {31'd0, we}, 32'd0);
      check("rst_drop", {31'd0, drop}, 32'd0);
      check("rst_busy", {16'd0, busy}, 32'd0);
      check("rst_waddr", {28'd0, w_addr}, 32'd0);
      check("rst_wdata", w_data, 32'd0);

      // single ALU write
      rst_n = 1'b1;
      alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 32'h11223344;
      #1;
      check("t1_ready", {31'd0, alu_ready}, 32'd1);
      push(1'b0, 4'd3, 32'h11223344);
      cyc();
      alu_valid = 1'b0;
      check("t1_we", {31'd0, we}, 32'd1);
      cyc();
      check("t1_we_low", {31'd0, we}, 32'd0);

      // both valid: ALU, load, ALU, load
      alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 32'hA1A1A1A1;
      ldu_valid = 1'b1; ldu_addr = 4'd2; ldu_data = 32'hB2B2B2B2;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("t2_alu_ready", {31'd0, alu_ready}, {31'd0, (i % 2) == 0});
         check("t2_ldu_ready", {31'd0, ldu_ready}, {31'd0, (i % 2) == 1});
         if (i % 2 == 0) push(1'b0, 4'd1, 32'hA1A1A1A1);
         else            push(1'b0, 4'd2, 32'hB2B2B2B2);
         cyc();
      end
      alu_valid = 1'b0; ldu_valid = 1'b0;
      cyc();

      // RAW stall on v5
      rsv_valid = 1'b1; rsv_addr = 4'd5;
      #1;
      check("t3_rsv_stall", {31'd0, stall}, 32'd0);
      cyc();
      rsv_valid = 1'b0; chk1 = 4'd5;
      #1;
      check("t3_busy", {16'd0, busy}, 32'h0020);
      check("t3_stall_a", {31'd0, stall}, 32'd1);
      cyc();
      alu_valid = 1'b1; alu_addr = 4'd5; alu_data = 32'h00000055;
      #1;
      check("t3_ready", {31'd0, alu_ready}, 32'd1);
      check("t3_stall_n", {31'd0, stall}, 32'd1);
      push(1'b0, 4'd5, 32'h00000055);
      cyc();
      alu_valid = 1'b0;
      #1;
      check("t3_stall_n1", {31'd0, stall}, 32'd1);
      cyc();
      check("t3_stall_n2", {31'd0, stall}, 32'd0);
      check("t3_busy_clr", {16'd0, busy}, 32'd0);
      chk1 = 4'd0;

      // writes to read-only v14 (ALU) and v0 (load)
      alu_valid = 1'b1; alu_addr = 4'd14; alu_data = 32'hBEEFBEEF;
      ldu_valid = 1'b1; ldu_addr = 4'd0;  ldu_data = 32'hDEADDEAD;
      #1;
      check("t4_alu_ready", {31'd0, alu_ready}, 32'd1);
      check("t4_ldu_wait", {31'd0, ldu_ready}, 32'd0);
      push(1'b1, 4'd14, 32'hBEEFBEEF);
      cyc();
      alu_valid = 1'b0;
      #1;
      check("t4_ldu_ready", {31'd0, ldu_ready}, 32'd1);
      push(1'b1, 4'd0, 32'hDEADDEAD);
      cyc();
      ldu_valid = 1'b0;
      cyc();
      check("t4_we", {31'd0, we}, 32'd0);
      check("t4_busy", {16'd0, busy}, 32'd0);
      check("t4_waddr_hold", {28'd0, w_addr}, 32'd5);
      check("t4_wdata_hold", w_data, 32'h00000055);

      // reservation in the commit cycle of v7: set wins
      alu_valid = 1'b1; alu_addr = 4'd7; alu_data = 32'h77777777;
      #1;
      check("t5_ready", {31'd0, alu_ready}, 32'd1);
      push(1'b0, 4'd7, 32'h77777777);
      cyc();
      alu_valid = 1'b0;
      rsv_valid = 1'b1; rsv_addr = 4'd7;
      #1;
      check("t5_stall", {31'd0, stall}, 32'd0);
      cyc();
      rsv_addr = 4'd13;
      #1;
      check("t5_busy7", {16'd0, busy}, 32'h0080);
      cyc();
      rsv_valid = 1'b0; chk1 = 4'd13;
      #1;
      check("t5_ro_ignored", {16'd0, busy}, 32'h0080);
      check("t5_ro_nostall", {31'd0, stall}, 32'd0);
      chk1 = 4'd0;

      // reset with busy=0x00A0 and a write in flight
      rsv_valid = 1'b1; rsv_addr = 4'd5;
      cyc();
      rsv_valid = 1'b0;
      alu_valid = 1'b1; alu_addr = 4'd9;  alu_data = 32'h99999999;
      ldu_valid = 1'b1; ldu_addr = 4'd10; ldu_data = 32'hAAAAAAAA;
      #1;
      check("t6_busy", {16'd0, busy}, 32'h00A0);
      check("t6_ldu_fav", {31'd0, ldu_ready}, 32'd1);
      push(1'b0, 4'd10, 32'hAAAAAAAA);
      cyc();
      rst_n = 1'b0;
      #1;
      check("t6_rst_alu_rdy", {31'd0, alu_ready}, 32'd0);
      check("t6_rst_ldu_rdy", {31'd0, ldu_ready}, 32'd0);
      cyc();
      rst_n = 1'b1;
      #1;
      check("t6_busy_clr", {16'd0, busy}, 32'd0);
      check("t6_we", {31'd0, we}, 32'd0);
      check("t6_drop", {31'd0, drop}, 32'd0);
      check("t6_alu_fav", {31'd0, alu_ready}, 32'd1);
      check("t6_ldu_wait", {31'd0, ldu_ready}, 32'd0);
      push(1'b0, 4'd9, 32'h99999999);
      cyc();
      alu_valid = 1'b0;
      #1;
      check("t6_ldu_ready", {31'd0, ldu_ready}, 32'd1);
      push(1'b0, 4'd10, 32'hAAAAAAAA);
      cyc();
      ldu_valid = 1'b0;
      cyc();
      cyc();
      check("queue_empty", q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
